// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//
// Transmit-side frame serializer for the AHB UART. A word is taken over a
// valid/ready handshake. It is then shifted onto TXD as follows:
//   - a start bit,
//   - DWIDTH data bits, LSB first,
//   - an optional parity bit,
//   - one or two stop bits.
// Bit timing comes from the one-cycle baud_tick pulse of the baud generator.
//
// Parameters
//   DWIDTH     data bits per frame (5..9)
//
// Ports
//   HCLK       system clock, rising edge
//   HRESETn    asynchronous active-low reset
//   baud_tick  one-HCLK pulse per bit period
//   tx_data    word to transmit
//   tx_valid   tx_data is valid
//   tx_ready   framer can accept a word (IDLE only)
//   PARITYEN   1 = insert a parity bit
//   PARITYSEL  0 = even, 1 = odd; the forced bit value when STICKP=1
//   STICKP     1 = stick parity (parity bit = PARITYSEL)
//   STOP2      1 = two stop bits
//   TXD        registered serial output, idles at 1
//   tx_busy    frame in progress, including the armed wait (= !tx_ready)
//
// Optional feature
//   UART_TX_FRAMER_ASSERT_EN compiles in SVA checks. The checks cover:
//     - the parity bit value,
//     - ready/busy exclusivity,
//     - the idle level of TXD,
//     - TXD changing only on baud ticks.
//   Functional behaviour is the same whether or not the macro is defined.
// ---------------------------------------------------------------------------
module uart_tx_framer #(
  parameter int DWIDTH = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              baud_tick,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              PARITYEN,
  input  logic              PARITYSEL,
  input  logic              STICKP,
  input  logic              STOP2,
  output logic              TXD,
  output logic              tx_busy
);

  localparam int            CW       = $clog2(DWIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DWIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              last_bit;
  logic [DWIDTH-1:0] shift_q;
  logic [CW-1:0]     bit_cnt_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              txd_q;

  // Parity bit for a word.
  // Stick mode forces the bit to PARITYSEL. Otherwise the bit is chosen so
  // that the number of ones over data plus parity is even (sel=0) or odd
  // (sel=1).
  function automatic logic parity_of(input logic [DWIDTH-1:0] data,
                                     input logic              sel,
                                     input logic              stick);
    logic p;
    if (stick) p = sel;
    else       p = sel ? ~^data : ^data;
    return p;
  endfunction

  assign last_bit = (bit_cnt_q == LAST_BIT);
  assign tx_ready = (state == IDLE);
  assign tx_busy  = ~tx_ready;
  assign TXD      = txd_q;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments. Every
  // register then samples the pre-edge values, so the result does not
  // depend on the order of the always_ff blocks.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the case
  // statement. A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        // A tick in the accept cycle is deliberately ignored, so the
        // start bit always lasts a full tick period.
        if (tx_valid) begin
          accept    = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED:  if (baud_tick) state_nxt = START;
      START:  if (baud_tick) state_nxt = DATA;
      DATA:   if (baud_tick && last_bit) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (baud_tick) state_nxt = STOP;
      STOP: begin
        // The last stop bit is finished by IDLE and ARMED, since the next
        // start bit waits for a tick anyway. STOP therefore only has to
        // wait out the extra period of a second stop bit. This lets
        // back-to-back frames run with no idle gap.
        if (!stop2_q || baud_tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: latched frame settings, shift register, bit counter, TXD
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      if (accept) begin
        // Freeze the word and the frame format for the whole frame.
        shift_q   <= tx_data;
        par_en_q  <= PARITYEN;
        par_bit_q <= parity_of(tx_data, PARITYSEL, STICKP);
        stop2_q   <= STOP2;
      end
      if (baud_tick) begin
        unique case (state)
          ARMED: txd_q <= 1'b0;
          START: begin
            txd_q     <= shift_q[0];
            shift_q   <= {1'b0, shift_q[DWIDTH-1:1]};
            bit_cnt_q <= '0;
          end
          DATA: begin
            if (last_bit) begin
              txd_q <= par_en_q ? par_bit_q : 1'b1;
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= {1'b0, shift_q[DWIDTH-1:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          PARITY:  txd_q <= 1'b1;
          default: txd_q <= 1'b1;
        endcase
      end
    end
  end

`ifdef UART_TX_FRAMER_ASSERT_EN
  // Shadow copy of the accepted word and parity mode, so the parity check
  // does not rely on par_bit_q.
  logic [DWIDTH-1:0] chk_data_q;
  logic              chk_sel_q;
  logic              chk_stick_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      chk_data_q  <= '0;
      chk_sel_q   <= 1'b0;
      chk_stick_q <= 1'b0;
    end else if (accept) begin
      chk_data_q  <= tx_data;
      chk_sel_q   <= PARITYSEL;
      chk_stick_q <= STICKP;
    end
  end

  a_parity_bit: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (state == PARITY) |-> (TXD == parity_of(chk_data_q, chk_sel_q, chk_stick_q)))
    else $error("uart_tx_framer: wrong parity bit on TXD");

  a_ready_busy: assert property (@(posedge HCLK) disable iff (!HRESETn)
    !(tx_ready && tx_busy))
    else $error("uart_tx_framer: tx_ready and tx_busy both high");

  a_idle_level: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (state == IDLE || state == ARMED) |-> TXD)
    else $error("uart_tx_framer: TXD low while idle or armed");

  a_txd_on_tick: assert property (@(posedge HCLK) disable iff (!HRESETn)
    !baud_tick |=> $stable(TXD))
    else $error("uart_tx_framer: TXD changed without baud_tick");
`endif

endmodule

// File: tb/tb_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Scoreboard bench for uart_tx_framer. There are two instances: one with
// DWIDTH=8 and one with DWIDTH=5.
//
// When a word is issued, the stimulus pushes the hand-computed bit sequence
// of its frame into a per-instance queue. A monitor per instance watches
// TXD on every baud tick. On each start bit it pops the expected frame and
// then compares each following bit against it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_framer;

  typedef struct {
    logic [15:0] bits;   // bit n is the level expected after the n-th tick
    int          len;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  int         period;
  logic [7:0] data8;
  logic [4:0] data5;
  logic       valid8, valid5;
  logic       ready8, ready5, busy8, busy5, txd8, txd5;
  logic       pen, psel, stick, stop2;

  int     checks = 0;
  int     passed = 0;
  int     cyc    = 0;
  frame_t q0[$], q1[$];
  int     starts0[$], starts1[$];
  int     done0 = 0, done1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_framer #(.DWIDTH(8)) dut8 (
    .HCLK(clk), .HRESETn(rst_n), .baud_tick(baud_tick),
    .tx_data(data8), .tx_valid(valid8), .tx_ready(ready8),
    .PARITYEN(pen), .PARITYSEL(psel), .STICKP(stick), .STOP2(stop2),
    .TXD(txd8), .tx_busy(busy8)
  );

  uart_tx_framer #(.DWIDTH(5)) dut5 (
    .HCLK(clk), .HRESETn(rst_n), .baud_tick(baud_tick),
    .tx_data(data5), .tx_valid(valid5), .tx_ready(ready5),
    .PARITYEN(pen), .PARITYSEL(psel), .STICKP(stick), .STOP2(stop2),
    .TXD(txd5), .tx_busy(busy5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic rdy(input int idx);
    return (idx == 0) ? ready8 : ready5;
  endfunction

  function automatic logic bsy(input int idx);
    return (idx == 0) ? busy8 : busy5;
  endfunction

  task automatic set_valid(input int idx, input logic v);
    if (idx == 0) valid8 = v;
    else          valid5 = v;
  endtask

  // Tick generator: one pulse every `period` cycles, updated just after posedge.
  initial begin
    int tc;
    tc        = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tc        = (tc + 1 >= period) ? 0 : tc + 1;
      baud_tick = (tc == period - 1);
    end
  end

  // Monitor: samples TXD after every tick edge and checks it against the scoreboard.
  task automatic monitor(input int idx);
    frame_t f;
    int     pos;
    bit     in_frame;
    logic   t, b;
    in_frame = 1'b0;
    pos      = 0;
    forever begin
      @(posedge clk);
      t = baud_tick;
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;   // a reset abandons the frame in flight
        continue;
      end
      if (!t) continue;
      b = (idx == 0) ? txd8 : txd5;
      if (!in_frame) begin
        if (b !== 1'b0) continue;
        if (idx == 0) begin
          check("dut0_start_expected", q0.size() > 0, 1'b1);
          if (q0.size() == 0) continue;
          f = q0.pop_front();
          starts0.push_back(cyc);
        end else begin
          check("dut1_start_expected", q1.size() > 0, 1'b1);
          if (q1.size() == 0) continue;
          f = q1.pop_front();
          starts1.push_back(cyc);
        end
        pos      = 0;
        in_frame = 1'b1;
      end
      check($sformatf("dut%0d_bit%0d", idx, pos), b, f.bits[pos]);
      pos++;
      if (pos == f.len) begin
        in_frame = 1'b0;
        if (idx == 0) done0++;
        else          done1++;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // Issue one word.
  //   - The expected frame is built from the data bits plus the
  //     hand-computed parity bit exp_par, and pushed to the scoreboard.
  //   - sync_tick makes the accept edge coincide with a baud tick.
  //   - keep_valid leaves tx_valid high after acceptance.
  task automatic send(input int idx, input logic [8:0] d, input logic p_en, input logic p_sel,
                      input logic stk, input logic s2, input logic exp_par,
                      input bit sync_tick, input bit keep_valid, output int acc_cyc);
    frame_t f;
    int     n, w, b;
    w      = (idx == 0) ? 8 : 5;
    f.bits = '0;
    f.bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < w; i++) begin
      f.bits[n] = d[i];
      n++;
    end
    if (p_en) begin
      f.bits[n] = exp_par;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (s2) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = n;
    if (idx == 0) q0.push_back(f);
    else          q1.push_back(f);

    @(posedge clk);
    #2;
    if (idx == 0) data8 = d[7:0];
    else          data5 = d[4:0];
    pen   = p_en;
    psel  = p_sel;
    stick = stk;
    stop2 = s2;
    if (!sync_tick) set_valid(idx, 1'b1);
    b = 0;
    while (!(rdy(idx) && (!sync_tick || baud_tick)) && b < 2000) begin
      @(posedge clk);
      #2;
      b++;
    end
    check($sformatf("dut%0d_accept_wait", idx), b < 2000, 1'b1);
    set_valid(idx, 1'b1);
    @(posedge clk);
    #2;
    acc_cyc = cyc;
    if (!keep_valid) set_valid(idx, 1'b0);
    check($sformatf("dut%0d_busy_after_accept", idx), bsy(idx), 1'b1);
  endtask

  task automatic wait_done(input int idx, input int target);
    int b;
    b = 0;
    while (((idx == 0) ? done0 : done1) < target && b < 5000) begin
      @(posedge clk);
      b++;
    end
    check($sformatf("dut%0d_frame_done_%0d", idx, target),
          ((idx == 0) ? done0 : done1) >= target, 1'b1);
  endtask

  initial begin
    int acc, s, rc, b, k, n0;
    rst_n  = 1'b0;
    period = 6;
    valid8 = 1'b0;
    valid5 = 1'b0;
    data8  = '0;
    data5  = '0;
    pen    = 1'b0;
    psel   = 1'b0;
    stick  = 1'b0;
    stop2  = 1'b0;
    n0     = 0;

    // Reset state
    #12;
    check("reset_txd",   txd8,   1'b1);
    check("reset_ready", ready8, 1'b1);
    check("reset_busy",  busy8,  1'b0);
    check("reset_txd5",  txd5,   1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Basic 8N1, 0x55
    send(0, 9'h055, 0, 0, 0, 0, 0, 0, 0, acc);
    check("8n1_ready_low", ready8, 1'b0);
    b = 0;
    while (!ready8 && b < 2000) begin
      @(posedge clk);
      #2;
      b++;
    end
    rc = cyc;
    n0++;
    wait_done(0, n0);
    s = starts0[$];
    check("8n1_ready_window", (rc > s + 9 * period) && (rc < s + 10 * period), 1'b1);

    // Even / odd parity on 0x07 (three ones)
    send(0, 9'h007, 1, 0, 0, 0, 1, 0, 0, acc);
    n0++;
    wait_done(0, n0);
    send(0, 9'h007, 1, 1, 0, 0, 0, 0, 0, acc);
    n0++;
    wait_done(0, n0);

    // Stick parity
    send(0, 9'h000, 1, 1, 1, 0, 1, 0, 0, acc);
    n0++;
    wait_done(0, n0);
    send(0, 9'h0FF, 1, 0, 1, 0, 0, 0, 0, acc);
    n0++;
    wait_done(0, n0);

    // Streaming with two stop bits, tx_valid held high
    send(0, 9'h0A5, 0, 0, 0, 1, 0, 0, 1, acc);
    send(0, 9'h03C, 0, 0, 0, 1, 0, 0, 0, acc);
    n0 += 2;
    wait_done(0, n0);
    check("stream_start_gap", starts0[$] - starts0[$-1], 11 * period);

    // Reset during data bit 3
    send(0, 9'h0F0, 0, 0, 0, 0, 0, 0, 0, acc);
    k = starts0.size();
    b = 0;
    while (starts0.size() == k && b < 2000) begin
      @(posedge clk);
      b++;
    end
    check("rst_frame_started", starts0.size() > k, 1'b1);
    k = 0;
    b = 0;
    while (k < 4 && b < 2000) begin
      @(posedge clk);
      if (baud_tick) k++;
      b++;
    end
    #2;
    check("rst_pre_txd_d3", txd8, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_async_txd",   txd8,   1'b1);
    check("rst_async_ready", ready8, 1'b1);
    check("rst_async_busy",  busy8,  1'b0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    send(0, 9'h081, 0, 0, 0, 0, 0, 0, 0, acc);
    n0++;
    wait_done(0, n0);

    // Accept coincident with baud_tick: start bit one full period later
    send(0, 9'h03C, 0, 0, 0, 0, 0, 1, 0, acc);
    n0++;
    wait_done(0, n0);
    check("coincident_start_delay", starts0[$] - acc, period);

    // Config inputs changed mid-frame: frame uses latched even parity, one stop
    send(0, 9'h007, 1, 0, 0, 0, 1, 0, 0, acc);
    pen   = 1'b0;
    psel  = 1'b1;
    stick = 1'b1;
    stop2 = 1'b1;
    data8 = 8'h00;
    n0++;
    wait_done(0, n0);

    // DWIDTH=5, 0x1F (five ones), even parity -> 1
    send(1, 9'h01F, 1, 0, 0, 0, 1, 0, 0, acc);
    wait_done(1, 1);

    // Continuous baud_tick: one bit per HCLK
    period = 1;
    send(0, 9'h03A, 0, 0, 0, 0, 0, 0, 0, acc);
    n0++;
    wait_done(0, n0);

    repeat (20) @(posedge clk);
    check("scoreboard0_empty", q0.size(), 0);
    check("scoreboard1_empty", q1.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
